// File: rtl/imsic_msi_tx.sv
// imsic_msi_tx: validates MSI writes, queues them, and replays each as a slow level pulse
// (setup / hold / gap) suited to a receiver behind a two-flop synchroniser.
module imsic_msi_tx #(
    parameter int unsigned NR_INTP_FILES   = 7,
    parameter int unsigned NR_HARTS        = 4,
    parameter int unsigned NR_HARTS_WIDTH  = 2,
    parameter int unsigned NR_SRC          = 32,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned HOLD_CYC        = 4,
    parameter int unsigned GAP_CYC         = 4,
    parameter int unsigned NR_SRC_WIDTH    = $clog2(NR_SRC),
    parameter int unsigned INTP_FILE_WIDTH = $clog2(NR_INTP_FILES),
    parameter int unsigned MSI_INFO_WIDTH  = NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH,
    parameter int unsigned ADDR_WIDTH      = NR_HARTS_WIDTH + INTP_FILE_WIDTH + 12
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_wr_vld,
    output logic                      o_wr_rdy,
    input  logic [ADDR_WIDTH-1:0]     i_wr_addr,
    input  logic [31:0]               i_wr_data,
    output logic [MSI_INFO_WIDTH-1:0] o_msi_info,
    output logic                      o_msi_info_vld,
    output logic                      o_drop,
    output logic                      o_busy
);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, SETUP, HOLD, GAP} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          tmr_q, tmr_d;
    logic                      vld_q, vld_d;
    logic                      drop_q, drop_d;
    logic [MSI_INFO_WIDTH-1:0] info_q, info_d;
    logic [MSI_INFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [MSI_INFO_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]            fifo_cnt_q, fifo_cnt_d;

    logic [NR_HARTS_WIDTH-1:0]  hart;
    logic [INTP_FILE_WIDTH-1:0] file;
    logic                       ok, accept, push, pop, empty, full;

    assign hart     = i_wr_addr[ADDR_WIDTH-1 -: NR_HARTS_WIDTH];
    assign file     = i_wr_addr[12 +: INTP_FILE_WIDTH];
    assign empty    = (fifo_cnt_q == '0);
    assign full     = (fifo_cnt_q == (PTR_W+1)'(FIFO_DEPTH));
    assign accept   = i_wr_vld & o_wr_rdy;
    assign ok       = (i_wr_addr[11:0] == 12'h0) && (32'(file) < NR_INTP_FILES) &&
                      (32'(hart) < NR_HARTS) && (i_wr_data != 32'h0) && (i_wr_data < NR_SRC);
    assign push     = accept & ok;

    assign o_wr_rdy       = !full;
    assign o_busy         = !empty || (state_q != IDLE);
    assign o_msi_info     = info_q;
    assign o_msi_info_vld = vld_q;
    assign o_drop         = drop_q;

    always_comb begin
        mem_d = mem_q;
        if (push)
            mem_d[wr_ptr_q] = {hart, file, i_wr_data[NR_SRC_WIDTH-1:0]};
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        drop_d     = accept & !ok;
    end

    // info only moves on a pop, so it stays put through setup, hold, gap and idle
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        vld_d   = vld_q;
        info_d  = info_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                info_d  = mem_q[rd_ptr_q];
                state_d = SETUP;
            end
            SETUP: begin
                state_d = HOLD;
                vld_d   = 1'b1;
                tmr_d   = '0;
            end
            HOLD: if (tmr_q == CNT_W'(HOLD_CYC - 1)) begin
                state_d = GAP;
                vld_d   = 1'b0;
                tmr_d   = '0;
            end else begin
                tmr_d = tmr_q + CNT_W'(1);
            end
            GAP: if (tmr_q == CNT_W'(GAP_CYC - 1)) begin
                tmr_d   = '0;
                pop     = !empty;
                info_d  = empty ? info_q : mem_q[rd_ptr_q];
                state_d = empty ? IDLE : SETUP;
            end else begin
                tmr_d = tmr_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            vld_q      <= 1'b0;
            drop_q     <= 1'b0;
            info_q     <= '0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            vld_q      <= vld_d;
            drop_q     <= drop_d;
            info_q     <= info_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end
endmodule

// File: tb/tb_imsic_msi_tx.sv
// tb_imsic_msi_tx: directed and random writes checked each cycle against a pulse-schedule model,
// plus a synchronising receiver model that must see every queued MSI.
module tb_imsic_msi_tx;
    localparam int FD = 4, HC = 4, GC = 4, AW = 17, IW = 10;

    logic          clk = 1'b0, rstn = 1'b1, i_wr_vld = 1'b0;
    logic [AW-1:0] i_wr_addr = '0;
    logic [31:0]   i_wr_data = '0;
    logic          o_wr_rdy, o_msi_info_vld, o_drop, o_busy;
    logic [IW-1:0] o_msi_info;

    int n_chk = 0, n_fail = 0, cyc = 0, drop_t = -100;
    int rise_q[$], info_q[$], rx_q[$];
    logic s1, s2, s3;

    imsic_msi_tx dut (
        .clk(clk), .rstn(rstn), .i_wr_vld(i_wr_vld), .o_wr_rdy(o_wr_rdy),
        .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .o_msi_info(o_msi_info),
        .o_msi_info_vld(o_msi_info_vld), .o_drop(o_drop), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
            rx_q.delete();
        end else begin
            s1 <= o_msi_info_vld; s2 <= s1; s3 <= s2;
            if (s2 && !s3) rx_q.push_back(int'(o_msi_info));
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic int model_count();
        int popped = 0;
        foreach (rise_q[k]) if (rise_q[k] - 1 <= cyc) popped++;
        return rise_q.size() - popped;
    endfunction

    // Each MSI rises two cycles after acceptance or one full period after the previous rise.
    function automatic void model_push(logic [AW-1:0] a, logic [31:0] d);
        int hart = int'(a) / 32768, file = (int'(a) / 4096) % 8, off = int'(a) % 4096, r = cyc + 2;
        if (off != 0 || file >= 7 || hart >= 4 || d == 0 || d >= 32) begin
            drop_t = cyc;
            return;
        end
        if (rise_q.size() > 0 && rise_q[$] + 1 + HC + GC > r) r = rise_q[$] + 1 + HC + GC;
        rise_q.push_back(r);
        info_q.push_back(hart * 256 + file * 32 + int'(d));
    endfunction

    task automatic check_all();
        int ev = 0, ei = 0, eb = 0, cnt = model_count();
        foreach (rise_q[k]) begin
            if (rise_q[k] <= cyc && cyc <= rise_q[k] + HC - 1) ev = 1;
            if (rise_q[k] - 1 <= cyc) ei = info_q[k];
            if (rise_q[k] - 1 <= cyc && cyc <= rise_q[k] + HC + GC - 1) eb = 1;
        end
        if (cnt > 0) eb = 1;
        chk("vld", 32'(o_msi_info_vld), 32'(ev));
        chk("info", 32'(o_msi_info), 32'(ei));
        chk("busy", 32'(o_busy), 32'(eb));
        chk("rdy", 32'(o_wr_rdy), 32'(cnt < FD));
        chk("drop", 32'(o_drop), 32'(drop_t == cyc));
    endtask

    task automatic step(output bit acc);
        acc = rstn && i_wr_vld && o_wr_rdy;
        @(posedge clk);
        cyc++;
        if (acc) model_push(i_wr_addr, i_wr_data);
        #1;
        check_all();
    endtask

    task automatic idle(int n);
        bit acc;
        i_wr_vld = 1'b0;
        repeat (n) step(acc);
    endtask

    task automatic wr(int hart, int file, int off, int data);
        bit acc = 1'b0;
        i_wr_addr = AW'(hart * 32768 + file * 4096 + off);
        i_wr_data = 32'(data);
        i_wr_vld  = 1'b1;
        for (int i = 0; i < 60 && !acc; i++) step(acc);
        i_wr_vld = 1'b0;
        if (!acc) chk("wr_accept_timeout", 32'(0), 32'(1));
    endtask

    task automatic do_reset();
        bit acc;
        i_wr_vld = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("rst_vld", 32'(o_msi_info_vld), 32'(0));
        chk("rst_info", 32'(o_msi_info), 32'(0));
        chk("rst_drop", 32'(o_drop), 32'(0));
        chk("rst_rdy", 32'(o_wr_rdy), 32'(1));
        chk("rst_busy", 32'(o_busy), 32'(0));
        rise_q.delete();
        info_q.delete();
        drop_t = -100;
        repeat (2) step(acc);
        rstn = 1'b1;
    endtask

    task automatic drain_cmp(string tag);
        int tend = (rise_q.size() > 0) ? rise_q[$] + HC + GC + 4 : cyc;
        bit acc;
        i_wr_vld = 1'b0;
        for (int i = 0; i < 400 && cyc <= tend; i++) step(acc);
        chk({tag, "_rx_count"}, 32'(rx_q.size()), 32'(info_q.size()));
        foreach (info_q[k]) chk({tag, "_rx_info"}, (k < rx_q.size()) ? 32'(rx_q[k]) : 32'hdead, 32'(info_q[k]));
    endtask

    initial begin
        bit acc;
        do_reset();
        idle(3);

        wr(1, 1, 0, 5);
        idle(1);
        chk("lat_vld_e1", 32'(o_msi_info_vld), 32'(0));
        idle(1);
        chk("lat_vld_e2", 32'(o_msi_info_vld), 32'(1));
        chk("single_info", 32'(o_msi_info), 32'h125);
        drain_cmp("single");

        wr(0, 0, 0, 0);
        chk("drop_d0", 32'(o_drop), 32'(1));
        wr(0, 0, 0, 32);
        chk("drop_d32", 32'(o_drop), 32'(1));
        wr(0, 0, 4, 3);
        chk("drop_off", 32'(o_drop), 32'(1));
        wr(0, 7, 0, 3);
        chk("drop_file7", 32'(o_drop), 32'(1));
        idle(12);
        chk("drop_no_busy", 32'(o_busy), 32'(0));
        drain_cmp("drops");

        for (int i = 1; i <= 5; i++) wr(0, 0, 0, i);
        chk("full_rdy", 32'(o_wr_rdy), 32'(0));
        drain_cmp("b2b");

        for (int i = 1; i <= 3; i++) wr(2, 3, 0, 10 + i);
        for (int i = 0; i < 40 && !(model_count() == 2 && rise_q[$ - 1] - 2 == cyc); i++) idle(1);
        chk("pp_setup_count", 32'(model_count()), 32'(2));
        wr(3, 6, 0, 31);
        chk("pp_count", 32'(model_count()), 32'(2));
        chk("pp_rdy", 32'(o_wr_rdy), 32'(1));
        drain_cmp("pushpop");

        for (int i = 0; i < 120; i++) begin
            i_wr_vld  = 1'($urandom_range(0, 1));
            i_wr_addr = AW'($urandom_range(0, 3) * 32768 + $urandom_range(0, 7) * 4096 +
                            (($urandom_range(0, 9) == 0) ? 8 : 0));
            i_wr_data = 32'($urandom_range(0, 36));
            step(acc);
        end
        drain_cmp("random");

        for (int i = 1; i <= 4; i++) wr(1, 2, 0, 20 + i);
        for (int i = 0; i < 20 && !(o_msi_info_vld && model_count() == 3); i++) idle(1);
        chk("hold_before_rst", 32'(o_msi_info_vld), 32'(1));
        do_reset();
        idle(30);
        chk("post_rst_busy", 32'(o_busy), 32'(0));
        chk("post_rst_rx", 32'(rx_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/imsic_msi_tx.md
IMSIC_MSI_TX -- requirements
Module: imsic_msi_tx

Interface
REQ-001 SHALL have parameter NR_INTP_FILES, default 7, meaning interrupt files per hart (M, S, VS1..VSn).
REQ-002 SHALL have parameter NR_HARTS, default 4, meaning harts served.
REQ-003 SHALL have parameter NR_HARTS_WIDTH, default 2, meaning hart ID width.
REQ-004 SHALL have parameter NR_SRC, default 32, meaning interrupt identities per file (ID 0 is invalid).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4 (power of 2, >=2), meaning pending MSI entries.
REQ-006 SHALL have parameter HOLD_CYC, default 4 (>=1), meaning cycles o_msi_info_vld stays high per MSI.
REQ-007 SHALL have parameter GAP_CYC, default 4 (>=1), meaning minimum low cycles after each pulse.
REQ-008 SHALL have derived parameters NR_SRC_WIDTH=$clog2(NR_SRC), INTP_FILE_WIDTH=$clog2(NR_INTP_FILES), MSI_INFO_WIDTH=NR_HARTS_WIDTH+INTP_FILE_WIDTH+NR_SRC_WIDTH, ADDR_WIDTH=NR_HARTS_WIDTH+INTP_FILE_WIDTH+12.
REQ-009 Ports: clk  in  1  sole clock, rising edge.
REQ-010 Ports: rstn  in  1  asynchronous active-low reset.
REQ-011 Ports: i_wr_vld  in  1  MSI write request valid.
REQ-012 Ports: o_wr_rdy  out  1  request accepted when i_wr_vld & o_wr_rdy.
REQ-013 Ports: i_wr_addr  in  ADDR_WIDTH  {hart, file, 12-bit page offset}.
REQ-014 Ports: i_wr_data  in  32  requested interrupt identity (seteipnum_le value).
REQ-015 Ports: o_msi_info  out  MSI_INFO_WIDTH  {hart[MSB], file, eiid[LSB]}.
REQ-016 Ports: o_msi_info_vld  out  1  level pulse, sampled by receiver through 2-flop sync plus rising-edge detect.
REQ-017 Ports: o_drop  out  1  one-cycle pulse, accepted request discarded.
REQ-018 Ports: o_busy  out  1  FIFO non-empty or FSM not IDLE.

Function
REQ-019 o_wr_rdy SHALL equal !fifo_full (combinational from registered count).
REQ-020 Accepted request SHALL be pushed only if offset==0, file<NR_INTP_FILES, hart<NR_HARTS, data!=0, data<NR_SRC; else o_drop=1 the next cycle, no push.
REQ-021 Pushed entry SHALL be {hart, file, data[NR_SRC_WIDTH-1:0]}.
REQ-022 FIFO SHALL support push and pop in the same cycle (count unchanged); pointers wrap modulo FIFO_DEPTH.
REQ-023 FSM states: IDLE, SETUP, HOLD, GAP.
REQ-024 IDLE: if FIFO non-empty -> pop head into o_msi_info, go SETUP; else stay.
REQ-025 SETUP (1 cycle, vld=0, info stable) -> HOLD, o_msi_info_vld<=1, counter cleared.
REQ-026 HOLD: vld=1 for exactly HOLD_CYC cycles, then vld<=0, -> GAP.
REQ-027 GAP: vld=0 for exactly GAP_CYC cycles; at end, FIFO non-empty -> pop, SETUP; else IDLE.
REQ-028 o_msi_info SHALL change only on entry to SETUP; stable through SETUP, HOLD, GAP and IDLE.
REQ-029 o_msi_info_vld and o_msi_info SHALL be registered outputs.
REQ-030 Latency: request accepted at edge E0 into empty FIFO with FSM IDLE -> SETUP at E1 and vld rises at E2.
REQ-031 Back-to-back MSIs SHALL be spaced 1+HOLD_CYC+GAP_CYC cycles rising-edge to rising-edge.
REQ-032 Counter width SHALL be $clog2(max(HOLD_CYC,GAP_CYC)+1); no overflow.
REQ-033 MSIs SHALL be delivered in acceptance order; none lost except via o_drop.

Reset
REQ-034 On rstn low, immediately: o_msi_info_vld=0, o_msi_info=0, o_drop=0, FIFO empty (o_wr_rdy=1), o_busy=0, FSM=IDLE, counter=0.
REQ-035 Reset mid-pulse SHALL abort the MSI; queued entries are discarded.

Verification
REQ-036 Single write addr={2'd1,3'd1,12'h0}, data=5 -> o_msi_info={1,1,5}, vld high 4 cycles starting 2 cycles after accept, o_drop never.
REQ-037 Write data=0, data=32, offset=12'h004, file=7 -> o_drop pulse each, no vld pulse, FIFO stays empty.
REQ-038 Five back-to-back writes (ids 1..5) -> o_wr_rdy low after 4 queued, pulses in order 1..5, rising edges 9 cycles apart.
REQ-039 Simultaneous push and pop at count=2 -> count stays 2, order preserved.
REQ-040 rstn asserted during HOLD with 3 queued -> vld=0 same cycle; after release o_busy=0, no further pulses.
REQ-041 Model receiver (2-flop sync, rising-edge sample) -> every queued MSI sampled with exact o_msi_info value.
